// File: rtl/cpu_sram_like_bridge_if.sv
// Bundles the core-side fetch/data ports and the two SRAM-like master buses.
// The bridge uses the slave modport; the surrounding system (core + memory) uses master.
interface cpu_sram_like_bridge_if;
    logic        inst_en;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        i_stall;

    logic        data_en;
    logic [3:0]  data_wen;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        d_stall;

    logic        longest_stall;

    logic        inst_req;
    logic        inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr_o;
    logic [31:0] inst_wdata;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata_i;

    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata_i;

    modport slave (
        input  inst_en, inst_addr, data_en, data_wen, data_addr, data_wdata, longest_stall,
               inst_addr_ok, inst_data_ok, inst_rdata_i,
               data_addr_ok, data_data_ok, data_rdata_i,
        output inst_rdata, i_stall, data_rdata, d_stall,
               inst_req, inst_wr, inst_size, inst_addr_o, inst_wdata,
               data_req, data_wr, data_size, data_addr_o, data_wdata_o
    );

    modport master (
        output inst_en, inst_addr, data_en, data_wen, data_addr, data_wdata, longest_stall,
               inst_addr_ok, inst_data_ok, inst_rdata_i,
               data_addr_ok, data_data_ok, data_rdata_i,
        input  inst_rdata, i_stall, data_rdata, d_stall,
               inst_req, inst_wr, inst_size, inst_addr_o, inst_wdata,
               data_req, data_wr, data_size, data_addr_o, data_wdata_o
    );
endinterface

// File: rtl/cpu_sram_like_bridge.sv
// Converts the core's enable/stall fetch and data ports into two independent
// SRAM-like master channels, each with one outstanding transaction at most.
module cpu_sram_like_bridge (
    input  logic                         clk,
    input  logic                         rst,
    cpu_sram_like_bridge_if.slave        bus
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      i_state_reg, i_state_next;
    logic [31:0] i_addr_reg;
    logic [31:0] i_rdata_reg;
    logic        i_capture, i_data_hit;

    state_t      d_state_reg, d_state_next;
    logic [31:0] d_addr_reg;
    logic [31:0] d_wdata_reg;
    logic [1:0]  d_size_reg;
    logic        d_wr_reg;
    logic [31:0] d_rdata_reg;
    logic        d_capture, d_data_hit;

    // Byte-enable pattern to transfer size; odd patterns fall back to a full word.
    function automatic logic [1:0] wen_size(input logic [3:0] wen);
        case (wen)
            4'b0011, 4'b1100:                   wen_size = 2'd1;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: wen_size = 2'd0;
            default:                            wen_size = 2'd2;
        endcase
    endfunction

    assign i_capture  = (i_state_reg == IDLE) && bus.inst_en;
    assign i_data_hit = bus.inst_data_ok &&
                        (((i_state_reg == REQ) && bus.inst_addr_ok) || (i_state_reg == WAIT));
    assign d_capture  = (d_state_reg == IDLE) && bus.data_en;
    assign d_data_hit = bus.data_data_ok &&
                        (((d_state_reg == REQ) && bus.data_addr_ok) || (d_state_reg == WAIT));

    // ---------------- instruction channel ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_state_reg <= IDLE;
            i_addr_reg  <= '0;
            i_rdata_reg <= '0;
        end else begin
            i_state_reg <= i_state_next;
            if (i_capture)  i_addr_reg  <= bus.inst_addr;
            if (i_data_hit) i_rdata_reg <= bus.inst_rdata_i;
        end
    end

    always_comb begin
        i_state_next = i_state_reg;
        case (i_state_reg)
            IDLE: if (bus.inst_en) i_state_next = REQ;
            REQ:  if (bus.inst_addr_ok) i_state_next = bus.inst_data_ok ? DONE : WAIT;
            WAIT: if (bus.inst_data_ok) i_state_next = DONE;
            DONE: if (!bus.longest_stall) i_state_next = IDLE;
            default: i_state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.inst_req    = (i_state_reg == REQ);
        bus.inst_wr     = 1'b0;
        bus.inst_size   = 2'd2;
        bus.inst_addr_o = i_addr_reg;
        bus.inst_wdata  = '0;
        bus.inst_rdata  = i_rdata_reg;
        bus.i_stall     = bus.inst_en && (i_state_reg != DONE);
    end

    // ---------------- data channel ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_state_reg <= IDLE;
            d_addr_reg  <= '0;
            d_wdata_reg <= '0;
            d_size_reg  <= '0;
            d_wr_reg    <= 1'b0;
            d_rdata_reg <= '0;
        end else begin
            d_state_reg <= d_state_next;
            if (d_capture) begin
                // Reads go out word-aligned; writes keep the byte address for the lane select.
                d_addr_reg  <= (bus.data_wen == 4'b0000) ? {bus.data_addr[31:2], 2'b00}
                                                         : bus.data_addr;
                d_wdata_reg <= bus.data_wdata;
                d_size_reg  <= wen_size(bus.data_wen);
                d_wr_reg    <= (bus.data_wen != 4'b0000);
            end
            if (d_data_hit) d_rdata_reg <= bus.data_rdata_i;
        end
    end

    always_comb begin
        d_state_next = d_state_reg;
        case (d_state_reg)
            IDLE: if (bus.data_en) d_state_next = REQ;
            REQ:  if (bus.data_addr_ok) d_state_next = bus.data_data_ok ? DONE : WAIT;
            WAIT: if (bus.data_data_ok) d_state_next = DONE;
            DONE: if (!bus.longest_stall) d_state_next = IDLE;
            default: d_state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.data_req     = (d_state_reg == REQ);
        bus.data_wr      = d_wr_reg;
        bus.data_size    = d_size_reg;
        bus.data_addr_o  = d_addr_reg;
        bus.data_wdata_o = d_wdata_reg;
        bus.data_rdata   = d_rdata_reg;
        bus.d_stall      = bus.data_en && (d_state_reg != DONE);
    end

endmodule

// File: tb/tb_cpu_sram_like_bridge.sv
// Directed bench for cpu_sram_like_bridge: fetch, stores, aligned reads, hold,
// backpressure and mid-transaction reset, with returned words tracked in a queue.
module tb_cpu_sram_like_bridge;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [31:0] exp_q[$];

    cpu_sram_like_bridge_if bus ();

    cpu_sram_like_bridge dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic sb_pop(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=%h expected=<queue empty>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            chk(tag, obs, e);
        end
    endtask

    logic [3:0] wen_tab  [7];
    logic [1:0] size_tab [7];

    initial begin
        checks = 0;
        errors = 0;
        wen_tab  = '{4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b1000, 4'b0110, 4'b0101};
        size_tab = '{2'd2,    2'd1,    2'd1,    2'd0,    2'd0,    2'd2,    2'd2};

        rst = 1'b1;
        bus.inst_en = 0; bus.inst_addr = 0;
        bus.data_en = 0; bus.data_wen = 0; bus.data_addr = 0; bus.data_wdata = 0;
        bus.longest_stall = 0;
        bus.inst_addr_ok = 0; bus.inst_data_ok = 0; bus.inst_rdata_i = 0;
        bus.data_addr_ok = 0; bus.data_data_ok = 0; bus.data_rdata_i = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_inst_req", {31'b0, bus.inst_req}, 32'd0);
        chk("rst_data_req", {31'b0, bus.data_req}, 32'd0);
        chk("rst_inst_rd", bus.inst_rdata, 32'd0);
        chk("rst_data_rd", bus.data_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Fetch: addr_ok in the first REQ cycle, data two cycles later.
        tick();
        bus.inst_en = 1; bus.inst_addr = 32'hBFC0_0000; #1;
        chk("f_stall_idle", {31'b0, bus.i_stall}, 32'd1);
        chk("f_req_idle", {31'b0, bus.inst_req}, 32'd0);
        tick();
        chk("f_req", {31'b0, bus.inst_req}, 32'd1);
        chk("f_addr_o", bus.inst_addr_o, 32'hBFC0_0000);
        chk("f_size", {30'b0, bus.inst_size}, 32'd2);
        chk("f_wr", {31'b0, bus.inst_wr}, 32'd0);
        bus.inst_addr_ok = 1; bus.inst_addr = 32'h1234_5678;
        tick();
        bus.inst_addr_ok = 0; #1;
        chk("f_req_wait", {31'b0, bus.inst_req}, 32'd0);
        chk("f_stall_wait", {31'b0, bus.i_stall}, 32'd1);
        tick();
        chk("f_stall_wait2", {31'b0, bus.i_stall}, 32'd1);
        bus.inst_data_ok = 1; bus.inst_rdata_i = 32'h3C08_BFAF;
        exp_q.push_back(32'h3C08_BFAF);
        tick();
        bus.inst_data_ok = 0; bus.inst_rdata_i = 32'hFFFF_FFFF; #1;
        chk("f_stall_done", {31'b0, bus.i_stall}, 32'd0);
        sb_pop("f_rdata", bus.inst_rdata);
        bus.inst_en = 0;
        tick();
        chk("f_rdata_held", bus.inst_rdata, 32'h3C08_BFAF);
        chk("f_req_idle2", {31'b0, bus.inst_req}, 32'd0);

        // Byte store, completed with addr_ok and data_ok together.
        bus.data_en = 1; bus.data_wen = 4'b0100;
        bus.data_addr = 32'h8000_1002; bus.data_wdata = 32'h00AB_0000; #1;
        chk("s_stall_idle", {31'b0, bus.d_stall}, 32'd1);
        tick();
        chk("s_req", {31'b0, bus.data_req}, 32'd1);
        chk("s_wr", {31'b0, bus.data_wr}, 32'd1);
        chk("s_size", {30'b0, bus.data_size}, 32'd0);
        chk("s_addr_o", bus.data_addr_o, 32'h8000_1002);
        chk("s_wdata_o", bus.data_wdata_o, 32'h00AB_0000);
        chk("s_stall_req", {31'b0, bus.d_stall}, 32'd1);
        bus.data_addr_ok = 1; bus.data_data_ok = 1; bus.data_rdata_i = 32'h1111_2222;
        exp_q.push_back(32'h1111_2222);
        tick();
        bus.data_addr_ok = 0; bus.data_data_ok = 0; #1;
        chk("s_stall_done", {31'b0, bus.d_stall}, 32'd0);
        sb_pop("s_rdata", bus.data_rdata);
        bus.data_en = 0;
        tick();

        // Aligned read, then hold in DONE under longest_stall while data_ok is stray.
        bus.data_en = 1; bus.data_wen = 4'b0000; bus.data_addr = 32'h8000_1003;
        tick();
        chk("r_addr_o", bus.data_addr_o, 32'h8000_1000);
        chk("r_size", {30'b0, bus.data_size}, 32'd2);
        chk("r_wr", {31'b0, bus.data_wr}, 32'd0);
        bus.data_addr_ok = 1;
        tick();
        bus.data_addr_ok = 0; #1;
        chk("r_req_wait", {31'b0, bus.data_req}, 32'd0);
        bus.data_data_ok = 1; bus.data_rdata_i = 32'hDEAD_BEEF; bus.longest_stall = 1;
        exp_q.push_back(32'hDEAD_BEEF);
        tick();
        bus.data_rdata_i = 32'h0BAD_0BAD; #1;
        sb_pop("r_rdata", bus.data_rdata);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("h_req_%0d", i), {31'b0, bus.data_req}, 32'd0);
            chk($sformatf("h_stall_%0d", i), {31'b0, bus.d_stall}, 32'd0);
            chk($sformatf("h_rdata_%0d", i), bus.data_rdata, 32'hDEAD_BEEF);
        end
        bus.longest_stall = 0; bus.data_data_ok = 0;
        tick();
        chk("h_idle_stall", {31'b0, bus.d_stall}, 32'd1);
        chk("h_idle_req", {31'b0, bus.data_req}, 32'd0);
        chk("h_idle_rdata", bus.data_rdata, 32'hDEAD_BEEF);
        tick();
        chk("h_new_req", {31'b0, bus.data_req}, 32'd1);
        bus.data_addr_ok = 1; bus.data_data_ok = 1; bus.data_rdata_i = 32'h1234_5678;
        exp_q.push_back(32'h1234_5678);
        tick();
        bus.data_addr_ok = 0; bus.data_data_ok = 0; #1;
        sb_pop("h_new_rdata", bus.data_rdata);
        bus.data_en = 0;
        tick();

        // Fetch backpressure: addr_ok withheld while inst_en drops.
        bus.inst_en = 1; bus.inst_addr = 32'h0040_0010;
        tick();
        bus.inst_en = 0; bus.inst_addr = 32'h0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("b_req_%0d", i), {31'b0, bus.inst_req}, 32'd1);
            chk($sformatf("b_addr_%0d", i), bus.inst_addr_o, 32'h0040_0010);
            tick();
        end
        bus.inst_addr_ok = 1; bus.inst_data_ok = 1; bus.inst_rdata_i = 32'hCAFE_F00D;
        exp_q.push_back(32'hCAFE_F00D);
        tick();
        bus.inst_addr_ok = 0; bus.inst_data_ok = 0; #1;
        chk("b_req_done", {31'b0, bus.inst_req}, 32'd0);
        sb_pop("b_rdata", bus.inst_rdata);
        tick();
        chk("b_req_idle", {31'b0, bus.inst_req}, 32'd0);

        // Write size decoding across byte-enable patterns.
        for (int i = 0; i < 7; i++) begin
            bus.data_en = 1; bus.data_wen = wen_tab[i];
            bus.data_addr = 32'h9000_0001 + i; bus.data_wdata = 32'hA5A5_0000 + i;
            tick();
            chk($sformatf("z_size_%0d", i), {30'b0, bus.data_size}, {30'b0, size_tab[i]});
            chk($sformatf("z_addr_%0d", i), bus.data_addr_o, 32'h9000_0001 + i);
            bus.data_addr_ok = 1; bus.data_data_ok = 1; bus.data_rdata_i = 32'h7700_0000 + i;
            exp_q.push_back(32'h7700_0000 + i);
            tick();
            bus.data_addr_ok = 0; bus.data_data_ok = 0; bus.data_en = 0; #1;
            sb_pop($sformatf("z_rdata_%0d", i), bus.data_rdata);
            tick();
        end

        // Reset while the data channel is waiting; later stray handshakes are ignored.
        bus.data_en = 1; bus.data_wen = 4'b1111;
        bus.data_addr = 32'h8000_2000; bus.data_wdata = 32'h55AA_55AA;
        tick();
        bus.data_addr_ok = 1;
        tick();
        bus.data_addr_ok = 0; bus.data_en = 0;
        rst = 1; #1;
        chk("x_req", {31'b0, bus.data_req}, 32'd0);
        chk("x_rdata", bus.data_rdata, 32'd0);
        chk("x_inst_rdata", bus.inst_rdata, 32'd0);
        chk("x_addr_o", bus.data_addr_o, 32'd0);
        chk("x_wr", {31'b0, bus.data_wr}, 32'd0);
        @(negedge clk);
        rst = 0;
        bus.data_data_ok = 1; bus.data_addr_ok = 1; bus.data_rdata_i = 32'hBAD0_BAD0;
        tick();
        bus.data_data_ok = 0; bus.data_addr_ok = 0; #1;
        chk("x_stray_rdata", bus.data_rdata, 32'd0);
        chk("x_stray_req", {31'b0, bus.data_req}, 32'd0);
        bus.data_en = 1; #1;
        chk("x_stall_after", {31'b0, bus.d_stall}, 32'd1);
        tick();
        chk("x_stall_req", {31'b0, bus.d_stall}, 32'd1);
        chk("x_req_again", {31'b0, bus.data_req}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
